bf_prog_loader: RTL and testbench
=================================

Name: bf_prog_loader

Overview:
- Boot/upload controller for the TinyBF core.
- Takes a framed byte stream from the UART receive path and halts the CPU.
- Writes the program image into program memory through the core's prog write port (prog_we/prog_waddr/prog_wdata), checks the frame checksum, then optionally restarts execution.
- Sits between the UART RX byte interface and bf_top's upload/control inputs; replaces the tied-off programming pins at board level.

Parameters:
- ADDR_W, 4, program memory address width; depth = 2**ADDR_W.
- DATA_W, 8, program word / UART byte width.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 50000, max clk_i cycles between bytes inside a frame before abort.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-low reset.
- rx_data_i  in  DATA_W  received byte.
- rx_valid_i  in  1  byte valid; transfer when rx_valid_i && rx_ready_o.
- rx_ready_o  out  1  loader can accept a byte.
- cpu_busy_i  in  1  core busy status.
- halt_o  out  1  one-cycle halt pulse to core.
- start_o  out  1  one-cycle start pulse to core.
- prog_we_o  out  1  program memory write strobe.
- prog_waddr_o  out  ADDR_W  write address.
- prog_wdata_o  out  DATA_W  write data.
- load_active_o  out  1  high from sync accept until frame end/abort.
- load_ok_o  out  1  sticky: last frame loaded with good checksum.
- load_err_o  out  1  sticky: last frame aborted (bad length, checksum or timeout).

Behaviour:
- Clock/reset: one clock clk_i; rst_i asynchronous, active-low. All outputs reset to 0 except rx_ready_o=1 (state IDLE); counters reset to 0.
- Frame format: SYNC_BYTE, LEN, LEN data bytes, CHK, where CHK = XOR of all data bytes. Data byte k is written to address k.
- IDLE: rx_ready_o=1. A non-sync byte is discarded. A sync byte clears load_ok_o and load_err_o, sets load_active_o, and moves to HALT.
- HALT: halt_o=1 for exactly this one cycle; rx_ready_o=0; goes to DRAIN.
- DRAIN: rx_ready_o=0 while cpu_busy_i=1; moves to LEN on the first cycle cpu_busy_i=0. The timeout does not run in DRAIN.
- LEN: accepts one byte.
  - LEN=0 or LEN>2**ADDR_W goes to ERR.
  - Otherwise: store the count, clear the address counter and running XOR, go to DATA.
- DATA: each accepted byte registers prog_we_o=1, prog_waddr_o=addr and prog_wdata_o=byte on the next cycle (1-cycle latency, single-cycle strobe), XORs into the checksum and increments addr. After the LEN-th byte, go to CHK.
- CHK: one byte.
  - Equal to the running XOR: go to START.
  - Not equal: go to ERR. Memory contents already written are left as is.
- START: start_o pulse (see optional feature); load_ok_o=1; load_active_o=0; return to IDLE.
- ERR: load_err_o=1; load_active_o=0; return to IDLE. No start pulse.
- Timeout: in LEN/DATA/CHK, a counter increments each cycle without a transfer. Reaching TIMEOUT_CYC-1 goes to ERR. A transfer in the same cycle as expiry wins, and the counter restarts at 0 on every transfer.
- rx_ready_o is 1 in IDLE/LEN/DATA/CHK and 0 in HALT/DRAIN/START/ERR.
- A sync byte inside a frame is treated as ordinary data (no resync).
- prog_waddr_o/prog_wdata_o hold their last value when prog_we_o=0.
- Reset mid-frame: immediate return to IDLE, flags cleared, any pulse truncated. Partially written memory is not restored.

Optional Feature:
- Macro: BF_LOADER_AUTOSTART_EN.
- Defined: START drives start_o=1 for one cycle after a good checksum, so the core runs from PC=0.
- Undefined: start_o is tied 0, START only sets load_ok_o, and the user starts via the board start pin.

Decomposition:
- Package bf_loader_pkg holds:
  - state enum (IDLE, HALT, DRAIN, LEN, DATA, CHK, START, ERR);
  - default SYNC_BYTE;
  - checksum function (byte XOR).
- Sub-module bf_loader_timeout holds the inter-byte timeout counter, with inputs run/kick and output expire.
- The FSM, address counter and checksum live in bf_prog_loader.

Test Plan:
- Good 3-byte frame:
  - Stimulus: A5,03,2B,3E,5B,CHK=4E with cpu_busy_i=0.
  - Expect: one halt_o pulse; writes (0,2B),(1,3E),(2,5B); load_ok_o=1; start_o pulse only with BF_LOADER_AUTOSTART_EN.
- Busy drain:
  - Stimulus: cpu_busy_i=1 for 20 cycles after sync.
  - Expect: rx_ready_o=0 for those cycles; LEN accepted only after busy falls; no writes while busy.
- Bad checksum:
  - Stimulus: A5,02,11,22,CHK=00.
  - Expect: writes (0,11),(1,22); load_err_o=1; no start_o; load_ok_o=0.
- Bad length:
  - Stimulus: LEN=00, and separately LEN=11 (17 > 16).
  - Expect: immediate ERR; no prog_we_o.
- Full depth and timeout:
  - Stimulus 1: 16-byte frame.
  - Expect: writes to addresses 0..15 with no wrap.
  - Stimulus 2: stall TIMEOUT_CYC cycles after the 5th data byte.
  - Expect: ERR; the next sync then clears load_err_o.
- Async reset:
  - Stimulus: rst_i low mid-DATA.
  - Expect: outputs 0, rx_ready_o=1, IDLE; a following good frame loads correctly.

Source files
------------

// File: rtl/bf_loader_pkg.sv
// Shared types and helpers for the TinyBF program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: loader state encoding, default frame sync marker,
// byte-wise checksum accumulate function.
package bf_loader_pkg;

    // Width of one program word / UART byte as used by the checksum helper.
    localparam int BF_WORD_W = 8;

    // Default frame start marker.
    localparam logic [BF_WORD_W-1:0] BF_SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_DRAIN = 3'd2,
        S_LEN   = 3'd3,
        S_DATA  = 3'd4,
        S_CHK   = 3'd5,
        S_START = 3'd6,
        S_ERR   = 3'd7
    } bf_ld_state_t;

    // Frame checksum is the XOR of all data bytes; fold one more byte in.
    function automatic logic [BF_WORD_W-1:0] bf_chk_acc(
        input logic [BF_WORD_W-1:0] acc,
        input logic [BF_WORD_W-1:0] b
    );
        return acc ^ b;
    endfunction

endpackage

// File: rtl/bf_loader_timeout.sv
// Inter-byte watchdog for the program loader.
// Latency: expire is combinational from the registered count and current run/kick.
// Backpressure: none; kick (a byte transfer) always wins over expiry.
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_run          : count while high; count held at 0 while low
//   i_kick         : a byte was transferred this cycle; restart count at 0
//   o_expire       : count has reached TIMEOUT_CYC-1 with no transfer this cycle
module bf_loader_timeout
    import bf_loader_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_kick,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_limit;

    assign w_at_limit = (r_cnt == LIMIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_run || i_kick) begin
            r_cnt <= '0;
        end else if (!w_at_limit) begin
            // Saturate so a stuck run never wraps back below the limit.
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_run && !i_kick && w_at_limit;

endmodule

// File: rtl/bf_prog_loader.sv
// Framed UART boot loader: halts TinyBF, writes SYNC,LEN,data..,CHK into program memory.
// Latency: each accepted data byte appears on prog_we/waddr/wdata one cycle later.
// Backpressure: rx_ready_o low in HALT/DRAIN/START/ERR; held off while the core is busy.
//
// Ports:
//   clk_i, rst_i         : clock, asynchronous active-low reset
//   rx_data_i/valid/ready: UART byte stream, transfer on valid && ready
//   cpu_busy_i           : core busy; loader waits for it to fall before taking LEN
//   halt_o, start_o      : one-cycle control pulses to the core
//   prog_we/waddr/wdata_o: program memory write port (addr/data hold when we=0)
//   load_active_o        : frame in progress; load_ok_o / load_err_o sticky results
//
// Build option: BF_LOADER_AUTOSTART_EN -- when defined, a good frame pulses start_o
// so the core runs from PC=0; otherwise start_o is tied low.
module bf_prog_loader
    import bf_loader_pkg::*;
#(
    parameter int                ADDR_W      = 4,
    parameter int                DATA_W      = BF_WORD_W,
    parameter logic [DATA_W-1:0] SYNC_BYTE   = BF_SYNC_BYTE_DEF,
    parameter int                TIMEOUT_CYC = 50000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    input  logic              cpu_busy_i,
    output logic              halt_o,
    output logic              start_o,
    output logic              prog_we_o,
    output logic [ADDR_W-1:0] prog_waddr_o,
    output logic [DATA_W-1:0] prog_wdata_o,
    output logic              load_active_o,
    output logic              load_ok_o,
    output logic              load_err_o
);

    localparam int DEPTH = 1 << ADDR_W;

    bf_ld_state_t r_state;
    bf_ld_state_t w_next;

    // Count and address need one extra bit so a full-depth frame (LEN = DEPTH) fits.
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_addr;
    logic [DATA_W-1:0] r_xor;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_active;
    logic              r_ok;
    logic              r_err;

    logic              w_rx_ready;
    logic              w_xfer;
    logic              w_is_sync;
    logic              w_len_bad;
    logic              w_last_data;
    logic              w_to_run;
    logic              w_to_expire;
    logic [ADDR_W:0]   w_addr_inc;

    // Ready depends on state only, so valid never feeds back into ready.
    assign w_rx_ready = (r_state == S_IDLE) || (r_state == S_LEN) ||
                        (r_state == S_DATA) || (r_state == S_CHK);
    assign w_xfer     = rx_valid_i && w_rx_ready;
    assign w_is_sync  = (rx_data_i == SYNC_BYTE);
    assign w_len_bad  = (rx_data_i == '0) || (32'(rx_data_i) > 32'(DEPTH));
    assign w_addr_inc = r_addr + 1'b1;
    assign w_last_data = (w_addr_inc == r_len);
    assign w_to_run   = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);

    bf_loader_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .i_clk    (clk_i),
        .i_rst_n  (rst_i),
        .i_run    (w_to_run),
        .i_kick   (w_xfer),
        .o_expire (w_to_expire)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A transfer is checked before expiry so a byte
    // arriving on the expiry cycle is still taken.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_xfer && w_is_sync) begin
                    w_next = S_HALT;
                end
            end
            S_HALT: begin
                w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!cpu_busy_i) begin
                    w_next = S_LEN;
                end
            end
            S_LEN: begin
                if (w_xfer) begin
                    w_next = w_len_bad ? S_ERR : S_DATA;
                end else if (w_to_expire) begin
                    w_next = S_ERR;
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    if (w_last_data) begin
                        w_next = S_CHK;
                    end
                end else if (w_to_expire) begin
                    w_next = S_ERR;
                end
            end
            S_CHK: begin
                if (w_xfer) begin
                    w_next = (rx_data_i == r_xor) ? S_START : S_ERR;
                end else if (w_to_expire) begin
                    w_next = S_ERR;
                end
            end
            S_START: begin
                w_next = S_IDLE;
            end
            S_ERR: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: length, address, running checksum, write port, flags.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_len    <= '0;
            r_addr   <= '0;
            r_xor    <= '0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_active <= 1'b0;
            r_ok     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer && w_is_sync) begin
                        r_ok     <= 1'b0;
                        r_err    <= 1'b0;
                        r_active <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (w_xfer && !w_len_bad) begin
                        r_len  <= rx_data_i[ADDR_W:0];
                        r_addr <= '0;
                        r_xor  <= '0;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_we    <= 1'b1;
                        r_waddr <= r_addr[ADDR_W-1:0];
                        r_wdata <= rx_data_i;
                        r_xor   <= bf_chk_acc(r_xor, rx_data_i);
                        r_addr  <= w_addr_inc;
                    end
                end
                S_START: begin
                    r_ok     <= 1'b1;
                    r_active <= 1'b0;
                end
                S_ERR: begin
                    r_err    <= 1'b1;
                    r_active <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rx_ready_o    = w_rx_ready;
    assign halt_o        = (r_state == S_HALT);
    assign prog_we_o     = r_we;
    assign prog_waddr_o  = r_waddr;
    assign prog_wdata_o  = r_wdata;
    assign load_active_o = r_active;
    assign load_ok_o     = r_ok;
    assign load_err_o    = r_err;

`ifdef BF_LOADER_AUTOSTART_EN
    assign start_o = (r_state == S_START);
`else
    // Core is started from the board start pin instead.
    assign start_o = 1'b0;
`endif

endmodule

// File: tb/tb_bf_prog_loader.sv
// Directed self-checking bench for bf_prog_loader.
// Latency: n/a.
// Backpressure: byte sender waits (bounded) on rx_ready_o.
module tb_bf_prog_loader;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int TO = 100;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [DW-1:0] rx_data_i = '0;
    logic          rx_valid_i = 1'b0;
    logic          rx_ready_o;
    logic          cpu_busy_i = 1'b0;
    logic          halt_o;
    logic          start_o;
    logic          prog_we_o;
    logic [AW-1:0] prog_waddr_o;
    logic [DW-1:0] prog_wdata_o;
    logic          load_active_o;
    logic          load_ok_o;
    logic          load_err_o;

    bf_prog_loader #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .rx_data_i     (rx_data_i),
        .rx_valid_i    (rx_valid_i),
        .rx_ready_o    (rx_ready_o),
        .cpu_busy_i    (cpu_busy_i),
        .halt_o        (halt_o),
        .start_o       (start_o),
        .prog_we_o     (prog_we_o),
        .prog_waddr_o  (prog_waddr_o),
        .prog_wdata_o  (prog_wdata_o),
        .load_active_o (load_active_o),
        .load_ok_o     (load_ok_o),
        .load_err_o    (load_err_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef BF_LOADER_AUTOSTART_EN
    localparam int EXP_START = 1;
`else
    localparam int EXP_START = 0;
`endif

    int checks = 0;
    int errs   = 0;

    // Observed write / pulse log, only appended by the monitor.
    logic [31:0] wq[$];
    int          halt_cnt  = 0;
    int          start_cnt = 0;

    always @(negedge clk_i) begin
        if (prog_we_o) wq.push_back(32'({prog_waddr_o, prog_wdata_o}));
        if (halt_o)    halt_cnt++;
        if (start_o)   start_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called and returns at a negedge; holds valid until the byte is taken.
    task automatic send(input logic [7:0] b);
        int n = 0;
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        while (!rx_ready_o && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 1000) check("send_rdy_wait", 32'(rx_ready_o), 32'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    int          wb, hb, sb;
    logic [7:0]  x;
    logic [7:0]  d;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        #12;
        check("rst_ready",  32'(rx_ready_o),    32'd1);
        check("rst_flags",  32'({halt_o, start_o, prog_we_o, load_active_o, load_ok_o, load_err_o}), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        idle(2);

        // ---------------- good 3-byte frame ----------------
        wb = wq.size(); hb = halt_cnt; sb = start_cnt;
        send(8'hA5);
        check("t1_active", 32'(load_active_o), 32'd1);
        send(8'h03); send(8'h2B); send(8'h3E); send(8'h5B); send(8'h4E);
        idle(3);
        check("t1_halts",  halt_cnt - hb,   1);
        check("t1_nwr",    wq.size() - wb,  3);
        check("t1_wr0",    wq[wb],          32'h02B);
        check("t1_wr1",    wq[wb+1],        32'h13E);
        check("t1_wr2",    wq[wb+2],        32'h25B);
        check("t1_ok",     32'(load_ok_o),  32'd1);
        check("t1_err",    32'(load_err_o), 32'd0);
        check("t1_active_end", 32'(load_active_o), 32'd0);
        check("t1_start",  start_cnt - sb,  EXP_START);

        // ---------------- busy drain, sync byte as data ----------------
        wb = wq.size(); hb = halt_cnt;
        cpu_busy_i = 1'b1;
        send(8'hA5);
        for (int i = 0; i < 20; i++) begin
            if (rx_ready_o !== 1'b0) check("t2_ready_busy", 32'(rx_ready_o), 32'd0);
            @(negedge clk_i);
        end
        check("t2_ready_low", 32'(rx_ready_o), 32'd0);
        check("t2_no_wr",     wq.size() - wb,  0);
        check("t2_halts",     halt_cnt - hb,   1);
        cpu_busy_i = 1'b0;
        idle(1);
        check("t2_ready_len", 32'(rx_ready_o), 32'd1);
        send(8'h02); send(8'h5A); send(8'hA5); send(8'hFF);
        idle(3);
        check("t2_nwr", wq.size() - wb, 2);
        check("t2_wr0", wq[wb],         32'h05A);
        check("t2_wr1", wq[wb+1],       32'h1A5);
        check("t2_ok",  32'(load_ok_o), 32'd1);

        // ---------------- bad checksum ----------------
        wb = wq.size(); sb = start_cnt;
        send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'h00);
        idle(3);
        check("t3_nwr",   wq.size() - wb,   2);
        check("t3_wr0",   wq[wb],           32'h011);
        check("t3_wr1",   wq[wb+1],         32'h122);
        check("t3_err",   32'(load_err_o),  32'd1);
        check("t3_ok",    32'(load_ok_o),   32'd0);
        check("t3_start", start_cnt - sb,   0);

        // ---------------- bad lengths ----------------
        wb = wq.size();
        send(8'hA5); send(8'h00);
        idle(3);
        check("t4a_err", 32'(load_err_o), 32'd1);
        check("t4a_nwr", wq.size() - wb,  0);
        check("t4a_ready", 32'(rx_ready_o), 32'd1);
        send(8'hA5); send(8'h11);
        idle(3);
        check("t4b_err", 32'(load_err_o), 32'd1);
        check("t4b_ok",  32'(load_ok_o),  32'd0);
        check("t4b_nwr", wq.size() - wb,  0);

        // ---------------- full depth ----------------
        wb = wq.size();
        x  = 8'h00;
        send(8'hA5); send(8'h10);
        for (int i = 0; i < 16; i++) begin
            d = 8'(i * 17 + 3);
            x = x ^ d;
            send(d);
        end
        send(x);
        idle(3);
        check("t5_nwr", wq.size() - wb, 16);
        for (int i = 0; i < 16; i++) begin
            d = 8'(i * 17 + 3);
            check($sformatf("t5_wr%0d", i), wq[wb+i], 32'({i[3:0], d}));
        end
        check("t5_ok",  32'(load_ok_o),  32'd1);
        check("t5_err", 32'(load_err_o), 32'd0);

        // ---------------- timeout ----------------
        wb = wq.size();
        send(8'hA5); send(8'h08);
        send(8'h01); send(8'h02); send(8'h03);
        idle(TO - 10);
        check("t6_no_early_err", 32'(load_err_o),    32'd0);
        check("t6_still_active", 32'(load_active_o), 32'd1);
        send(8'h04); send(8'h05);
        idle(TO + 10);
        check("t6_err",    32'(load_err_o),    32'd1);
        check("t6_active", 32'(load_active_o), 32'd0);
        check("t6_ready",  32'(rx_ready_o),    32'd1);
        check("t6_nwr",    wq.size() - wb,     5);
        send(8'hA5);
        check("t6_err_clr", 32'(load_err_o), 32'd0);
        send(8'h01); send(8'h77); send(8'h77);
        idle(3);
        check("t6_ok", 32'(load_ok_o), 32'd1);
        check("t6_wr", wq[wq.size()-1], 32'h077);

        // ---------------- async reset mid-DATA ----------------
        send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
        #2;
        rst_i = 1'b0;
        #1;
        check("t7_rst_ready", 32'(rx_ready_o), 32'd1);
        check("t7_rst_outs",  32'({halt_o, start_o, prog_we_o, load_active_o, load_ok_o, load_err_o}), 32'd0);
        check("t7_rst_waddr", 32'({prog_waddr_o, prog_wdata_o}), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        idle(1);
        check("t7_idle_ready", 32'(rx_ready_o), 32'd1);
        wb = wq.size();
        send(8'hA5); send(8'h02); send(8'hC3); send(8'h3C); send(8'hFF);
        idle(3);
        check("t7_nwr", wq.size() - wb, 2);
        check("t7_wr0", wq[wb],         32'h0C3);
        check("t7_wr1", wq[wb+1],       32'h13C);
        check("t7_ok",  32'(load_ok_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
